// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream selector with a one-entry output register.
// Channel chosen by external select (MODE=0) or round-robin (MODE=1).
module stream_mux_arb #(
   parameter int WIDTH = 8,
   parameter int N_CH  = 4,
   parameter int SEL_W = 2,
   parameter int MODE  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_ch
);

   if (SEL_W != $clog2(N_CH)) begin : g_bad_sel_w
      $error("SEL_W must equal clog2(N_CH)");
   end

   typedef enum logic {EMPTY, FULL} state_t;

   state_t             state;
   logic [SEL_W-1:0]   rr_ptr;
   logic [SEL_W-1:0]   grant;
   logic               grant_ok;
   logic               gvalid;
   logic               load_en;
   logic [WIDTH-1:0]   grant_data;

   logic [SEL_W-1:0]   rr_grant;
   logic               rr_found;
   logic               sel_ok;
   logic               sel_valid;

   assign out_valid = (state == FULL);
   assign load_en   = !out_valid || out_ready;

   // Out-of-range select codes never match a channel, so they grant nothing.
   always_comb begin
      sel_ok    = 1'b0;
      sel_valid = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (SEL_W'(i) == sel) begin
            sel_ok    = 1'b1;
            sel_valid = in_valid[i];
         end
      end
   end

   always_comb begin
      int idx;
      rr_found = 1'b0;
      rr_grant = '0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         for (int i = 0; i < N_CH; i++) begin
            if (!rr_found && i == idx && in_valid[i]) begin
               rr_found = 1'b1;
               rr_grant = SEL_W'(i);
            end
         end
      end
   end

   always_comb begin
      if (MODE == 1) begin
         grant    = rr_grant;
         grant_ok = rr_found;
         gvalid   = rr_found;
      end else begin
         grant    = sel;
         grant_ok = sel_ok;
         gvalid   = sel_valid;
      end
   end

   always_comb begin
      in_ready   = '0;
      grant_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant_ok && SEL_W'(i) == grant) begin
            in_ready[i] = load_en;
            grant_data  = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_data <= '0;
         out_ch   <= '0;
         rr_ptr   <= SEL_W'(N_CH - 1);
      end else if (load_en) begin
         if (gvalid) begin
            state    <= FULL;
            out_data <= grant_data;
            out_ch   <= grant;
            if (MODE == 1) rr_ptr <= grant;
         end else begin
            state <= EMPTY;
         end
      end
   end

endmodule
